// File: rtl/io_pkg.sv
// Shared IO command encodings and controller state type for io_channel_ctrl.
package io_pkg;

  localparam logic [1:0] IO_NONE = 2'b00;
  localparam logic [1:0] IO_IN   = 2'b01;
  localparam logic [1:0] IO_OUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_WAIT_PRESS   = 2'b01,
    ST_WAIT_RELEASE = 2'b10,
    ST_HALT         = 2'b11
  } io_state_e;

endpackage

// File: rtl/io_channel_ctrl_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional debounce (IO_DEBOUNCE_EN), edge pulses.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= btn_db;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees; any agreement clears it.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_db = db_q;
`else
  assign btn_db = sync2_q;
`endif

  assign btn_rise = btn_db & ~prev_q;
  assign btn_fall = ~btn_db & prev_q;

endmodule

// File: rtl/io_channel_ctrl.sv
// Multi-channel IO controller: button-confirmed IN capture, NUM_CH output registers,
// sticky BRK halt. Debounce of the button is enabled by defining IO_DEBOUNCE_EN.
module io_channel_ctrl
  import io_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned CH_BITS         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_in,
  input  logic [1:0]              io_cmd,
  input  logic [CH_BITS-1:0]      chan_sel,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH-1:0]        switches_in,
  input  logic                    button_in,
  input  logic                    brk,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    waiting_input,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       negative,
  output logic                    halted
);

  io_state_e               state_q, state_d;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [NUM_CH*WIDTH-1:0] out_q, out_d;
  logic [NUM_CH-1:0]       ch_we;
  logic                    wr_ok;
  logic                    btn_db, btn_rise, btn_fall;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clock),
    .rst_n    (reset_in),
    .btn_in   (button_in),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  // brk outranks any same-cycle command, so it also gates the channel writes.
  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ok      = 1'b0;
    if (state_q != ST_HALT) begin
      if (brk) begin
        state_d = ST_HALT;
      end else begin
        wr_ok = (io_cmd == IO_OUT);
        case (state_q)
          ST_IDLE: begin
            if (io_cmd == IO_IN) state_d = ST_WAIT_PRESS;
          end
          ST_WAIT_PRESS: begin
            if (btn_rise) begin
              rd_data_d = switches_in;
              state_d   = ST_WAIT_RELEASE;
            end
          end
          ST_WAIT_RELEASE: begin
            if (btn_fall) begin
              rd_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Selects outside 0..NUM_CH-1 match no channel, so the write is simply dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_we[k] = wr_ok && (chan_sel == CH_BITS'(k));
    assign out_d[k*WIDTH +: WIDTH] = ch_we[k] ? wr_data : out_q[k*WIDTH +: WIDTH];
    assign negative[k] = out_q[k*WIDTH + WIDTH - 1];
  end

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= ST_IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      out_q      <= out_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign out_data      = out_q;
  assign halted        = (state_q == ST_HALT);
  assign waiting_input = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Self-checking bench for io_channel_ctrl: directed handshake/OUT/BRK/reset steps plus
// randomized traffic, each cycle compared against a flag-based behavioural model.
module tb_io_channel_ctrl;
  import io_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_CH  = 2;
  localparam int CH_BITS = 2;
  localparam int DB      = 4;

  logic                    clock = 1'b0;
  logic                    reset_in = 1'b1;
  logic [1:0]              io_cmd = IO_NONE;
  logic [CH_BITS-1:0]      chan_sel = '0;
  logic [WIDTH-1:0]        wr_data = '0;
  logic [WIDTH-1:0]        switches_in = '0;
  logic                    button_in = 1'b0;
  logic                    brk = 1'b0;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_valid;
  logic                    waiting_input;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       negative;
  logic                    halted;

  always #5 clock = ~clock;

  io_channel_ctrl #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset_in(reset_in), .io_cmd(io_cmd), .chan_sel(chan_sel),
    .wr_data(wr_data), .switches_in(switches_in), .button_in(button_in), .brk(brk),
    .rd_data(rd_data), .rd_valid(rd_valid), .waiting_input(waiting_input),
    .out_data(out_data), .negative(negative), .halted(halted)
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Reference model: an IN is "pending" until released; "pressed" once captured.
  logic [WIDTH-1:0] m_rd;
  logic [WIDTH-1:0] m_out [NUM_CH];
  bit m_valid, m_pending, m_pressed, m_halt;
  bit m_s1, m_s2, m_db, m_dbprev;
  bit hist[$];

  task automatic model_reset();
    m_rd = '0; m_valid = 0; m_pending = 0; m_pressed = 0; m_halt = 0;
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbprev = 0;
    for (int k = 0; k < NUM_CH; k++) m_out[k] = '0;
    hist.delete();
  endtask

  function automatic logic [63:0] exp_out();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[k*WIDTH +: WIDTH] = m_out[k];
    return v;
  endfunction

  function automatic logic [63:0] exp_neg();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_out[k][WIDTH-1];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("rd_valid", 64'(rd_valid), 64'(m_valid));
    chk("waiting_input", 64'(waiting_input), 64'(m_pending));
    chk("out_data", 64'(out_data), exp_out());
    chk("negative", 64'(negative), exp_neg());
    chk("halted", 64'(halted), 64'(m_halt));
  endtask

  task automatic step(input logic [1:0] c, input int sel, input logic [WIDTH-1:0] wd,
                      input logic [WIDTH-1:0] sw, input bit b, input bit k);
    bit rise, fall, new_s2, db_new, flip;
    io_cmd = c; chan_sel = sel[CH_BITS-1:0]; wr_data = wd;
    switches_in = sw; button_in = b; brk = k;
    @(posedge clock);
    rise = m_db & ~m_dbprev;
    fall = ~m_db & m_dbprev;
    m_valid = 0;
    if (!m_halt) begin
      if (k) begin
        m_halt = 1; m_pending = 0;
      end else begin
        if (c == IO_OUT && sel < NUM_CH) m_out[sel] = wd;
        if (!m_pending) begin
          if (c == IO_IN) begin m_pending = 1; m_pressed = 0; end
        end else if (!m_pressed) begin
          if (rise) begin m_rd = sw; m_pressed = 1; end
        end else if (fall) begin
          m_pending = 0; m_valid = 1;
        end
      end
    end
    new_s2 = m_s1;
    m_s1 = b;
`ifdef IO_DEBOUNCE_EN
    hist.push_back(m_s2);
    if (hist.size() > DB) void'(hist.pop_front());
    flip = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] == m_db) flip = 0;
    db_new = flip ? ~m_db : m_db;
`else
    flip = 0;
    db_new = new_s2 | flip;
`endif
    m_s2 = new_s2;
    m_dbprev = m_db;
    m_db = db_new;
    #1;
    if (rd_valid === 1'b1) pulses++;
    check_all();
  endtask

  task automatic idle(input int n, input bit b, input logic [WIDTH-1:0] sw);
    for (int i = 0; i < n; i++) step(IO_NONE, 0, '0, sw, b, 0);
  endtask

  // Reset is dropped mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    #2 reset_in = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_in = 1'b1;
  endtask

  logic [1:0] rc;
  int hold, r;
  bit rb;

  initial begin
    do_reset();

    // IN handshake with a clean press
    step(IO_IN, 0, '0, 32'h0001_2345, 0, 0);
    idle(2, 0, 32'h0001_2345);
    pulses = 0;
    idle(12, 1, 32'h0001_2345);
    idle(12, 0, 32'h0000_0000);
    chk("in_capture", 64'(rd_data), 64'h0001_2345);
    chk("in_pulses", 64'(pulses), 64'd1);

    // Bouncing press with changing switches to expose the capture cycle
    step(IO_IN, 0, '0, 32'hA0, 0, 0);
    pulses = 0;
    step(IO_NONE, 0, '0, 32'hA1, 1, 0);
    step(IO_NONE, 0, '0, 32'hA2, 1, 0);
    step(IO_NONE, 0, '0, 32'hA3, 0, 0);
    step(IO_NONE, 0, '0, 32'hA4, 0, 0);
    for (int i = 0; i < 12; i++) step(IO_NONE, 0, '0, 32'hB0 + 32'(i), 1, 0);
    idle(12, 0, 32'hC0);
    chk("bounce_pulses", 64'(pulses), 64'd1);

    // OUT channels, including an out-of-range select
    step(IO_OUT, 1, 32'h8000_0007, '0, 0, 0);
    chk("out_ch1", 64'(out_data), 64'h8000_0007_0000_0000);
    chk("out_neg", 64'(negative), 64'h2);
    step(IO_OUT, 3, 32'h1234_5678, '0, 0, 0);
    chk("out_dropped", 64'(out_data), 64'h8000_0007_0000_0000);
    step(IO_OUT, 0, 32'h0000_00FF, '0, 0, 0);

    // Button already held when IN is issued: needs release then fresh press
    idle(8, 1, 32'hD0);
    step(IO_IN, 0, '0, 32'hD1, 1, 0);
    idle(8, 1, 32'hD2);
    idle(8, 0, 32'hD3);
    idle(10, 1, 32'hD4);
    idle(10, 0, 32'hD5);

    // BRK during WAIT_PRESS, then everything ignored
    step(IO_IN, 0, '0, 32'hE0, 0, 0);
    step(IO_NONE, 0, '0, 32'hE1, 1, 0);
    step(IO_NONE, 0, '0, 32'hE1, 1, 1);
    chk("brk_halted", 64'(halted), 64'd1);
    chk("brk_wait", 64'(waiting_input), 64'd0);
    idle(10, 1, 32'hE2);
    step(IO_OUT, 0, 32'hFFFF_FFFF, '0, 0, 0);
    step(IO_IN, 0, '0, 32'hE3, 0, 0);
    idle(10, 1, 32'hE4);
    idle(10, 0, 32'hE5);
    do_reset();

    // Simultaneous BRK and OUT
    step(IO_OUT, 0, 32'h0000_1234, '0, 0, 0);
    step(IO_OUT, 0, 32'hDEAD_BEEF, '0, 0, 1);
    chk("brk_vs_out", 64'(out_data), 64'h0000_0000_0000_1234);
    do_reset();

    // Reset mid-IN after capture
    step(IO_IN, 0, '0, 32'h77, 0, 0);
    idle(10, 1, 32'h77);
    do_reset();
    idle(10, 0, 32'h0);

    // Randomized traffic, reset between segments
    for (int seg = 0; seg < 4; seg++) begin
      hold = 0; rb = 0;
      for (int i = 0; i < 150; i++) begin
        if (hold == 0) begin rb = ~rb; hold = $urandom_range(1, 12); end
        hold--;
        r = $urandom_range(0, 9);
        rc = (r < 3) ? IO_IN : (r < 6) ? IO_OUT : (r == 6) ? 2'b11 : IO_NONE;
        step(rc, $urandom_range(0, 3), $urandom, $urandom, rb, ($urandom_range(0, 199) == 0));
      end
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
